// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the cache<->RAM port arbiter: FSM encoding, counter widths
// and the state-class decode helpers used by the top.
package mem_port_arbiter_pkg;

   localparam int unsigned CNT_W = 4;  // starvation counter, STARVE_MAX <= 15
   localparam int unsigned TMO_W = 8;  // timeout counter, TIMEOUT <= 255

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_BUSY_I = 3'd1,
      ST_BUSY_D = 3'd2,
      ST_RESP_I = 3'd3,
      ST_RESP_D = 3'd4
   } arb_state_e;

   function automatic logic is_busy(arb_state_e s);
      return (s == ST_BUSY_I) || (s == ST_BUSY_D);
   endfunction

   function automatic logic is_resp(arb_state_e s);
      return (s == ST_RESP_I) || (s == ST_RESP_D);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the I/D caches, the arbiter and RAM.
// slave = arbiter view, master = caches + RAM view.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 128
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [LINE_W-1:0] ram_wdata;
   logic [LINE_W-1:0] ram_rdata;
   logic              ram_resp;
   logic              err;
   logic              busy;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_resp,
      output i_rdata, i_resp, d_rdata, d_resp, ram_en, ram_we, ram_addr, ram_wdata,
             err, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, ram_en, ram_we, ram_addr, ram_wdata,
             err, busy
   );
endinterface

// File: rtl/mem_port_arbiter_pick2.sv
// Fixed D-over-I priority with a starvation override: once the I side has
// watched STARVE_MAX D grants go by, a pending I request wins.
module arb_pick2
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic             i_req_i,
   input  logic             d_req_i,
   input  logic [CNT_W-1:0] starve_cnt_i,
   output logic             grant_i_o,
   output logic             grant_d_o
);
   logic force_i;

   assign force_i   = i_req_i && (starve_cnt_i == CNT_W'(STARVE_MAX));
   assign grant_d_o = d_req_i && !force_i;
   assign grant_i_o = i_req_i && !grant_d_o;
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port arbiter between I-cache refill and D-cache refill/write-back.
// One line transaction in flight; every RAM wait is bounded by TIMEOUT.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned LINE_W     = 128,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              abort_q, abort_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [LINE_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
   logic              grant_i, grant_d;

   arb_pick2 #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .i_req_i     (bus.i_req),
      .d_req_i     (bus.d_req),
      .starve_cnt_i(starve_q),
      .grant_i_o   (grant_i),
      .grant_d_o   (grant_d)
   );

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      abort_d     = abort_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            tmo_d   = '0;
            abort_d = 1'b0;
            if (grant_d) begin
               state_d     = ST_BUSY_D;
               ram_we_d    = bus.d_we;
               ram_addr_d  = bus.d_addr;
               ram_wdata_d = bus.d_wdata;
               if (bus.i_req && (starve_q < CNT_W'(STARVE_MAX)))
                  starve_d = starve_q + CNT_W'(1);
            end else if (grant_i) begin
               state_d    = ST_BUSY_I;
               ram_we_d   = 1'b0;
               ram_addr_d = bus.i_addr;
               starve_d   = '0;
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (bus.ram_resp) begin
               state_d = (state_q == ST_BUSY_I) ? ST_RESP_I : ST_RESP_D;
               if (state_q == ST_BUSY_I)
                  i_rdata_d = bus.ram_rdata;
               else if (!ram_we_q)
                  d_rdata_d = bus.ram_rdata;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               // Abort: the requester still gets its response, flagged by err.
               state_d = (state_q == ST_BUSY_I) ? ST_RESP_I : ST_RESP_D;
               abort_d = 1'b1;
               if (state_q == ST_BUSY_I) i_rdata_d = '0;
               else                      d_rdata_d = '0;
            end
         end
         ST_RESP_I, ST_RESP_D: state_d = ST_IDLE;
         default:              state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         starve_q    <= '0;
         tmo_q       <= '0;
         abort_q     <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         abort_q     <= abort_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign bus.ram_en    = is_busy(state_q);
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.i_resp    = (state_q == ST_RESP_I);
   assign bus.d_resp    = (state_q == ST_RESP_D);
   assign bus.err       = abort_q && is_resp(state_q);
   assign bus.busy      = (state_q != ST_IDLE);
endmodule
